ex_mem: RTL and testbench
=========================

Name: ex_mem

Overview:
- Pipeline register between the EX stage and the MEM stage of the 5-stage core.
- Captures the EX write-back result (destination, write enable, data) and the HI/LO write request.
- Carries the multi-cycle multiply-accumulate scratch state (`hilo_temp`, `cnt`) back into EX while EX is stalled.
- Applies the pipeline stall vector and flush, inserting bubbles into MEM as required.

Parameters:
- DATA_W, 32, general register / HI / LO width.
- ADDR_W, 5, register address width.
- CNT_W, 2, multi-cycle step counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- stall  in  6  stall vector; bit3 = EX stalled, bit4 = MEM stalled
- flush  in  1  pipeline flush (exception/redirect)
- ex_wd  in  ADDR_W  destination register from EX
- ex_wreg  in  1  register write enable from EX
- ex_wdata  in  DATA_W  result from EX
- ex_whilo  in  1  HI/LO write enable from EX
- ex_hi  in  DATA_W  HI value from EX
- ex_lo  in  DATA_W  LO value from EX
- hilo_temp_i  in  2*DATA_W  multi-cycle partial product from EX
- cnt_i  in  CNT_W  multi-cycle step index from EX
- mem_wd  out  ADDR_W  destination to MEM
- mem_wreg  out  1  write enable to MEM
- mem_wdata  out  DATA_W  result to MEM
- mem_whilo  out  1  HI/LO write enable to MEM
- mem_hi  out  DATA_W  HI value to MEM
- mem_lo  out  DATA_W  LO value to MEM
- mem_valid  out  1  slot holds a real instruction
- hilo_temp_o  out  2*DATA_W  partial product fed back to EX
- cnt_o  out  CNT_W  step index fed back to EX

Behaviour:
- Reset: `rst` is synchronous, active-high. On a rising edge with `rst`=1, every output is cleared to 0.
- All outputs are registered. Latency from EX to MEM is 1 cycle.
- Per-edge priority, highest first:
  1. rst: all outputs 0.
  2. flush: payload outputs (`mem_*`) 0, `mem_valid` 0, `hilo_temp_o` 0, `cnt_o` 0. An in-flight multi-cycle operation is abandoned.
  3. Bubble (`stall[3]`=1 and `stall[4]`=0): payload outputs 0, `mem_valid` 0. `hilo_temp_o` <= `hilo_temp_i`, `cnt_o` <= `cnt_i`, so EX continues its multi-cycle sequence.
  4. Advance (`stall[3]`=0): payload <= `ex_*` inputs, `mem_valid` <= 1. `hilo_temp_o` <= 0, `cnt_o` <= 0; the multi-cycle sequence is complete.
  5. Hold (`stall[3]`=1 and `stall[4]`=1): payload and `mem_valid` unchanged. `hilo_temp_o` <= `hilo_temp_i`, `cnt_o` <= `cnt_i`.
- `stall[4]`=1 with `stall[3]`=0 is illegal: the stall controller never produces it. If it occurs anyway, treat it as Advance; the bench asserts that it never happens.
- A bubble payload is architecturally inert: `mem_wreg`=0 and `mem_whilo`=0.
- `cnt_o` wraps modulo 2^CNT_W with no saturation, since EX owns the sequencing.
- Reset or flush in the middle of a multi-cycle op clears the scratch state immediately (next edge).

Optional Feature:
- Macro: `EX_MEM_PERF_EN`.
- Defined:
  - Adds output `perf_bubble_cnt` [31:0], incremented on every Bubble edge.
  - Adds output `perf_hold_cnt` [31:0], incremented on every Hold edge.
  - Both counters saturate at 32'hFFFF_FFFF, clear on `rst`, and are not cleared by flush.
- Undefined: the ports and logic are absent. Core behaviour is identical in both cases.

Decomposition:
- Shared defines package:
  - Stall bit indices: STALL_IF=0, STALL_ID=1 … STALL_EX=3, STALL_MEM=4, STALL_WB=5.
  - ZeroWord, DoubleZeroWord.
  - RegBus and RegAddrBus widths.
- Sub-module `sat_counter32` (enable, clear, saturating) is instantiated twice under `EX_MEM_PERF_EN`.
- Everything else stays flat in `ex_mem`.

Test Plan:
- Reset: drive `rst`=1 with all inputs 0xFFFF_FFFF for 2 edges -> every output reads 0.
- Advance: `ex_wd`=5'd3, `ex_wreg`=1, `ex_wdata`=32'h1234_5678, `stall`=0 -> next edge `mem_wd`=3, `mem_wdata`=32'h1234_5678, `mem_valid`=1, `cnt_o`=0.
- Bubble: `stall`=6'b001111, `hilo_temp_i`=64'hA5, `cnt_i`=1 -> `mem_wreg`=0, `mem_valid`=0, `hilo_temp_o`=64'hA5, `cnt_o`=1; the following cycle with `stall`=0 captures the `ex_*` inputs and zeroes `cnt_o`.
- Hold: after an Advance with data 32'hDEAD_BEEF, apply `stall`=6'b011111 for 3 cycles with new inputs -> `mem_wdata` stays 32'hDEAD_BEEF and `hilo_temp_o` tracks `hilo_temp_i`.
- Flush mid-multicycle: `cnt_i`=1 under bubble, then `flush`=1 together with `stall`=6'b001111 -> `cnt_o`=0, `hilo_temp_o`=0, `mem_valid`=0.
- Perf (`EX_MEM_PERF_EN`): 4 bubble edges, 2 hold edges, 1 flush -> `perf_bubble_cnt`=4, `perf_hold_cnt`=2; `rst` then reads 0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared pipeline definitions: stall vector bit positions, bus widths, zero constants
// and the per-edge action classifier used by the EX/MEM register.
package ex_mem_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam int STALL_IF  = 0;
  localparam int STALL_ID  = 1;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [RegBus-1:0]   ZeroWord       = '0;
  localparam logic [2*RegBus-1:0] DoubleZeroWord = '0;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_FLUSH   = 2'd3
  } slot_act_e;

  // EX running with MEM stalled cannot come from the stall controller; it falls into Advance.
  function automatic slot_act_e slot_act(input logic ex_stall, input logic mem_stall,
                                         input logic flush);
    if (flush)          return ACT_FLUSH;
    else if (!ex_stall) return ACT_ADVANCE;
    else if (!mem_stall) return ACT_BUBBLE;
    else                return ACT_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem_sat_counter32.sv
// 32-bit event counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ex_mem.sv
// EX->MEM pipeline register with stall/flush bubble insertion and multi-cycle scratch feedback.
// Optional EX_MEM_PERF_EN adds saturating bubble/hold event counters.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int CNT_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] hilo_temp_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]    cnt_o
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]         perf_bubble_cnt,
  output logic [31:0]         perf_hold_cnt
`endif
);

  slot_act_e act;

  logic [ADDR_W-1:0]   wd_q, wd_d;
  logic                wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                whilo_q, whilo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                valid_q, valid_d;
  logic [2*DATA_W-1:0] hilo_temp_q, hilo_temp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Only the EX and MEM stall bits matter to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[STALL_WB], stall[2], stall[STALL_ID], stall[STALL_IF]};

  assign act = slot_act(stall[STALL_EX], stall[STALL_MEM], flush);

  always_comb begin
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    whilo_d     = whilo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    valid_d     = valid_q;
    hilo_temp_d = hilo_temp_i;
    cnt_d       = cnt_i;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        wd_d    = '0;
        wreg_d  = 1'b0;
        wdata_d = '0;
        whilo_d = 1'b0;
        hi_d    = '0;
        lo_d    = '0;
        valid_d = 1'b0;
        if (act == ACT_FLUSH) begin
          hilo_temp_d = '0;
          cnt_d       = '0;
        end
      end
      ACT_ADVANCE: begin
        wd_d        = ex_wd;
        wreg_d      = ex_wreg;
        wdata_d     = ex_wdata;
        whilo_d     = ex_whilo;
        hi_d        = ex_hi;
        lo_d        = ex_lo;
        valid_d     = 1'b1;
        hilo_temp_d = '0;
        cnt_d       = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      wdata_q     <= '0;
      whilo_q     <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      valid_q     <= 1'b0;
      hilo_temp_q <= '0;
      cnt_q       <= '0;
    end else begin
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      whilo_q     <= whilo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      valid_q     <= valid_d;
      hilo_temp_q <= hilo_temp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_wd      = wd_q;
  assign mem_wreg    = wreg_q;
  assign mem_wdata   = wdata_q;
  assign mem_whilo   = whilo_q;
  assign mem_hi      = hi_q;
  assign mem_lo      = lo_q;
  assign mem_valid   = valid_q;
  assign hilo_temp_o = hilo_temp_q;
  assign cnt_o       = cnt_q;

`ifdef EX_MEM_PERF_EN
  // Flush edges are counted as neither bubbles nor holds, and do not clear the counters.
  sat_counter32 u_bubble_cnt (
    .clk (clk),
    .clr (rst),
    .en  (act == ACT_BUBBLE),
    .cnt (perf_bubble_cnt)
  );

  sat_counter32 u_hold_cnt (
    .clk (clk),
    .clr (rst),
    .en  (act == ACT_HOLD),
    .cnt (perf_hold_cnt)
  );
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed plus randomized bench for ex_mem against a per-edge reference model.
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_valid;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_hold_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  // Expected state of the MEM slot and scratch feedback after the most recent edge.
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata;
  logic        m_whilo;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_valid;
  logic [63:0] m_ht;
  logic [1:0]  m_cnt;
  logic [31:0] m_pb;
  logic [31:0] m_ph;

  always #5 clk = ~clk;

  ex_mem dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .ex_wd       (ex_wd),
    .ex_wreg     (ex_wreg),
    .ex_wdata    (ex_wdata),
    .ex_whilo    (ex_whilo),
    .ex_hi       (ex_hi),
    .ex_lo       (ex_lo),
    .hilo_temp_i (hilo_temp_i),
    .cnt_i       (cnt_i),
    .mem_wd      (mem_wd),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .mem_whilo   (mem_whilo),
    .mem_hi      (mem_hi),
    .mem_lo      (mem_lo),
    .mem_valid   (mem_valid),
    .hilo_temp_o (hilo_temp_o),
    .cnt_o       (cnt_o)
`ifdef EX_MEM_PERF_EN
    ,
    .perf_bubble_cnt (perf_bubble_cnt),
    .perf_hold_cnt   (perf_hold_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slot();
    m_wd = '0; m_wreg = 0; m_wdata = '0; m_whilo = 0; m_hi = '0; m_lo = '0; m_valid = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      clear_slot();
      m_ht = '0; m_cnt = '0; m_pb = '0; m_ph = '0;
    end else if (flush) begin
      clear_slot();
      m_ht = '0; m_cnt = '0;
    end else if (!stall[3]) begin
      m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata; m_whilo = ex_whilo;
      m_hi = ex_hi; m_lo = ex_lo; m_valid = 1;
      m_ht = '0; m_cnt = '0;
    end else begin
      m_ht  = hilo_temp_i;
      m_cnt = cnt_i;
      if (!stall[4]) begin
        clear_slot();
        if (m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 1;
      end else if (m_ph != 32'hFFFF_FFFF) begin
        m_ph = m_ph + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("mem_wd", mem_wd, m_wd);
    chk("mem_wreg", mem_wreg, m_wreg);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_whilo", mem_whilo, m_whilo);
    chk("mem_hi", mem_hi, m_hi);
    chk("mem_lo", mem_lo, m_lo);
    chk("mem_valid", mem_valid, m_valid);
    chk("hilo_temp_o", hilo_temp_o, m_ht);
    chk("cnt_o", cnt_o, m_cnt);
`ifdef EX_MEM_PERF_EN
    chk("perf_bubble_cnt", perf_bubble_cnt, m_pb);
    chk("perf_hold_cnt", perf_hold_cnt, m_ph);
`endif
  endtask

  task automatic tick();
    chk("stall_legal", {63'd0, stall[4] & ~stall[3]}, 64'd0);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_payload();
    logic [31:0] r;
    r = $urandom;
    ex_wd    = r[4:0];
    ex_wreg  = r[5];
    ex_whilo = r[6];
    cnt_i    = r[8:7];
    ex_wdata = $urandom;
    ex_hi    = $urandom;
    ex_lo    = $urandom;
    hilo_temp_i = {$urandom, $urandom};
  endtask

  initial begin
    logic [31:0] r;
    logic [5:0]  s;

    // Reset with every input driven high
    rst = 1; flush = 1; stall = 6'h3F; ex_wd = 5'h1F; ex_wreg = 1; ex_wdata = 32'hFFFF_FFFF;
    ex_whilo = 1; ex_hi = 32'hFFFF_FFFF; ex_lo = 32'hFFFF_FFFF;
    hilo_temp_i = 64'hFFFF_FFFF_FFFF_FFFF; cnt_i = 2'b11;
    #2;
    tick();
    tick();
    chk("rst_valid", mem_valid, 0);
    chk("rst_wdata", mem_wdata, 0);

    // Advance
    rst = 0; flush = 0; stall = 6'b0;
    ex_wd = 5'd3; ex_wreg = 1; ex_wdata = 32'h1234_5678; ex_whilo = 0;
    ex_hi = 32'h0; ex_lo = 32'h0; hilo_temp_i = 64'h0; cnt_i = 2'd0;
    tick();
    chk("adv_wd", mem_wd, 3);
    chk("adv_wdata", mem_wdata, 32'h1234_5678);
    chk("adv_valid", mem_valid, 1);
    chk("adv_cnt", cnt_o, 0);

    // Bubble, then release
    stall = 6'b001111; hilo_temp_i = 64'hA5; cnt_i = 2'd1;
    tick();
    chk("bub_wreg", mem_wreg, 0);
    chk("bub_valid", mem_valid, 0);
    chk("bub_ht", hilo_temp_o, 64'hA5);
    chk("bub_cnt", cnt_o, 1);
    stall = 6'b0; ex_wd = 5'd7; ex_wdata = 32'hCAFE_F00D; cnt_i = 2'd2;
    tick();
    chk("rel_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("rel_cnt", cnt_o, 0);

    // Hold keeps the slot while scratch tracks EX
    ex_wdata = 32'hDEAD_BEEF;
    tick();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      rand_payload();
      tick();
      chk("hold_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("hold_ht", hilo_temp_o, hilo_temp_i);
    end

    // Flush in the middle of a multi-cycle op
    stall = 6'b001111; cnt_i = 2'd1; hilo_temp_i = 64'h1234_0000_5678;
    tick();
    chk("mc_cnt", cnt_o, 1);
    flush = 1;
    tick();
    chk("fl_cnt", cnt_o, 0);
    chk("fl_ht", hilo_temp_o, 0);
    chk("fl_valid", mem_valid, 0);
    flush = 0;

    // Perf event counting: 4 bubbles, 2 holds, 1 flush
    rst = 1; tick(); rst = 0;
    stall = 6'b001111;
    for (int i = 0; i < 4; i++) begin rand_payload(); tick(); end
    stall = 6'b011111;
    for (int i = 0; i < 2; i++) begin rand_payload(); tick(); end
    flush = 1; tick(); flush = 0;
`ifdef EX_MEM_PERF_EN
    chk("perf_bub4", perf_bubble_cnt, 4);
    chk("perf_hold2", perf_hold_cnt, 2);
    rst = 1; tick(); rst = 0;
    chk("perf_rst_bub", perf_bubble_cnt, 0);
    chk("perf_rst_hold", perf_hold_cnt, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      rst   = (r < 2);
      flush = (r >= 2 && r < 8);
      case ($urandom_range(0, 3))
        0: stall = 6'b000000;
        1: stall = 6'b001111;
        2: stall = 6'b011111;
        default: begin
          r = $urandom;
          s = r[5:0];
          if (s[4]) s[3] = 1'b1;
          stall = s;
        end
      endcase
      rand_payload();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
